// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fed by a ready/valid byte handshake.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic tx_n, wrap;
  assign wrap = cnt == CW'(SYMBOL_EDGE_TIME - 1);
  assign data_in_ready = (state == IDLE) && rst;
  always_comb begin
    state_n = state;
    cnt_n = wrap ? '0 : cnt + 1'b1;
    idx_n = idx;
    shreg_n = shreg;
    tx_n = serial_out;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (data_in_valid) begin
          state_n = START;
          shreg_n = data_in;
          tx_n = 1'b0;
        end
      end
      START: if (wrap) begin
        state_n = DATA;
        idx_n = 3'd0;
        tx_n = shreg[0];
      end
      DATA: if (wrap) begin
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
        tx_n = (idx == 3'd7) ? 1'b1 : shreg[idx + 3'd1];
      end
      STOP: if (wrap) state_n = IDLE;
    endcase
  end
  // serial_out is registered so the line never glitches
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shreg <= 8'd0;
      serial_out <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      serial_out <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of the 8N1 transmitter at N=10, plus a default-rate loopback.
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic data_in_valid = 1'b0;
  logic data_in_ready, serial_out;
  logic [7:0] d2 = 8'd0;
  logic v2 = 1'b0;
  logic r2, s2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .serial_out(serial_out)
  );

  uart_transmitter dut2 (
    .clk(clk), .rst(rst), .data_in(d2), .data_in_valid(v2),
    .data_in_ready(r2), .serial_out(s2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    chk({tag, " acc_rdy"}, data_in_ready, 1);
    data_in = b;
    data_in_valid = 1'b1;
    step(1);
    data_in_valid = 1'b0;
  endtask

  // Entered in the cycle right after the acceptance edge; leaves in cycle k+101.
  task automatic frame(input logic [7:0] b, input bit noise, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("%s line b%0d c%0d", tag, i, c), serial_out, bits[i]);
        chk($sformatf("%s busy b%0d c%0d", tag, i, c), data_in_ready, 0);
        if (noise) begin
          data_in = 8'($urandom);
          data_in_valid = ~data_in_valid;
        end
        step(1);
      end
    if (noise) data_in_valid = 1'b0;
    chk({tag, " idle_line"}, serial_out, 1);
    chk({tag, " ready_back"}, data_in_ready, 1);
  endtask

  task automatic send2(input logic [7:0] b, input string tag);
    for (int i = 0; i < 5000 && !r2; i++) step(1);
    chk({tag, " lb_rdy"}, r2, 1);
    d2 = b;
    v2 = 1'b1;
    step(1);
    v2 = 1'b0;
  endtask

  // Bench-side receiver: sample each bit at the middle of its 434-cycle period.
  task automatic rx2(input logic [7:0] b, input string tag);
    logic [7:0] got;
    got = 8'd0;
    for (int i = 0; i < 2000 && s2; i++) step(1);
    chk({tag, " lb_start_edge"}, s2, 0);
    step(217);
    chk({tag, " lb_start_mid"}, s2, 0);
    for (int j = 0; j < 8; j++) begin
      step(434);
      got[j] = s2;
    end
    step(434);
    chk({tag, " lb_stop"}, s2, 1);
    chk({tag, " lb_byte"}, got, b);
  endtask

  initial begin
    data_in = 8'hAA;
    data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_line", serial_out, 1);
      chk("rst_rdy", data_in_ready, 0);
    end
    rst = 1'b1;
    #1;
    chk("rel_rdy", data_in_ready, 1);
    data_in_valid = 1'b0;
    step(1);
    chk("rel_line", serial_out, 1);
    chk("rel_rdy2", data_in_ready, 1);

    send(8'hA5, "a5");
    frame(8'hA5, 1'b0, "a5");

    chk("b2b acc_rdy", data_in_ready, 1);
    data_in = 8'h00;
    data_in_valid = 1'b1;
    step(1);
    data_in = 8'hFF;
    frame(8'h00, 1'b0, "b2b0");
    step(1);
    data_in_valid = 1'b0;
    frame(8'hFF, 1'b0, "b2b1");

    send(8'h3C, "busy");
    frame(8'h3C, 1'b1, "busy");
    step(1);
    chk("busy no_extra", serial_out, 1);

    send(8'h81, "mid");
    step(45);
    chk("mid bit3", serial_out, 0);
    rst = 1'b0;
    step(1);
    chk("mid rst_line", serial_out, 1);
    chk("mid rst_rdy", data_in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid rel_rdy", data_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mid idle", serial_out, 1);
    end
    send(8'h7E, "7e");
    frame(8'h7E, 1'b0, "7e");

    send2(8'h55, "x55");
    rx2(8'h55, "x55");
    send2(8'hC3, "xc3");
    rx2(8'hC3, "xc3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
